hazard_ctrl: RTL and testbench

Central stall/flush/freeze sequencer for the 5-stage RV32 pipeline. It sits beside the forwarding logic and drives the pipeline-register enables and flushes. It handles four cases: load-use hazards the forwarding paths cannot cover, taken-branch/jump squashes, variable-latency data-memory waits with timeout, and ECALL/EBREAK halt/resume. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_ctrl_pkg.sv | 30 +++
 rtl/hazard_ctrl_cnt.sv | 19 +
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: FSM encoding, register-index
// width and the bundle of pipeline-register controls.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // Control patterns, ordered {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam ctrl_t CTRL_RUN   = ctrl_t'(7'b1111100);
    localparam ctrl_t CTRL_RST   = ctrl_t'(7'b0000011);
    localparam ctrl_t CTRL_HOLD  = ctrl_t'(7'b0000000);
    localparam ctrl_t CTRL_FLUSH = ctrl_t'(7'b1111111);
    localparam ctrl_t CTRL_STALL = ctrl_t'(7'b0011101);

endpackage

// File: rtl/hazard_ctrl_cnt.sv
// Saturating up-counter with synchronous clear, used for performance debug.
module hazard_ctrl_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/freeze sequencer: load-use stalls, branch squashes,
// data-memory wait freeze with timeout, and ECALL/EBREAK halt/resume.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_memread,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state, state_nxt;
    logic   [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic                mask, mask_nxt;
    logic                err_nxt;
    logic                freeze;
    logic                load_use;
    logic                stall_inc;
    logic                flush_inc;
    ctrl_t               ctrl;

    assign freeze   = dmem_req && !dmem_ready;
    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mask     <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mask     <= mask_nxt;
            mem_err  <= err_nxt;
        end
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        state_nxt = state;
        wait_nxt  = '0;
        mask_nxt  = mask;
        err_nxt   = mem_err;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            ctrl      = CTRL_RST;
            state_nxt = RUN;
            mask_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                HALT: begin
                    ctrl      = CTRL_HOLD;
                    halted    = 1'b1;
                    stall_inc = 1'b1;
                    if (resume && !mem_err) begin
                        state_nxt = RUN;
                        mask_nxt  = 1'b1;
                    end
                end
                default: begin
                    if (freeze) begin
                        // Resume mask survives a freeze: the ECALL has not yet left EX
                        ctrl      = CTRL_HOLD;
                        stall_inc = 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            err_nxt   = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            state_nxt = MEMWAIT;
                            wait_nxt  = wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        state_nxt = RUN;
                        mask_nxt  = 1'b0;
                        if (halt_req && !mask) begin
                            ctrl      = CTRL_HOLD;
                            state_nxt = HALT;
                        end else if (branch_taken) begin
                            ctrl      = CTRL_FLUSH;
                            flush_inc = 1'b1;
                        end else if (load_use) begin
                            ctrl      = CTRL_STALL;
                            stall_inc = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;

    hazard_ctrl_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    hazard_ctrl_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, each cycle
// compared against a cycle-level behavioural model of the sequencer rules.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO    = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
    logic             ifid_use_rs1, ifid_use_rs2, idex_memread;
    logic             branch_taken, halt_req, resume, dmem_req, dmem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state
    bit m_halt, m_err, m_mask;
    int m_waits, m_sc, m_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .resume       (resume),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .halted       (halted),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Evaluate one cycle: compare DUT against the model, then advance the model.
    task automatic step();
        logic [6:0] exp_ctrl;
        bit         lu;
        #1;
        lu = idex_memread && (idex_rd != 5'd0) &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        check("halted",  halted,    rst ? 1'b0 : m_halt);
        check("mem_err", mem_err,   m_err);
        check("stall",   stall_cnt, m_sc);
        check("flush",   flush_cnt, m_fc);
        if (rst) begin
            exp_ctrl = 7'b0000011;
            m_halt = 0; m_err = 0; m_mask = 0; m_waits = 0; m_sc = 0; m_fc = 0;
        end else if (m_halt) begin
            exp_ctrl = 7'b0000000;
            m_sc     = sat(m_sc + 1);
            m_waits  = 0;
            if (resume && !m_err) begin
                m_halt = 0;
                m_mask = 1;
            end
        end else if (dmem_req && !dmem_ready) begin
            exp_ctrl = 7'b0000000;
            m_sc     = sat(m_sc + 1);
            m_waits++;
            if (m_waits >= TO) begin
                m_err   = 1;
                m_halt  = 1;
                m_waits = 0;
            end
        end else begin
            m_waits = 0;
            if (halt_req && !m_mask) begin
                exp_ctrl = 7'b0000000;
                m_halt   = 1;
            end else if (branch_taken) begin
                exp_ctrl = 7'b1111111;
                m_fc     = sat(m_fc + 1);
            end else if (lu) begin
                exp_ctrl = 7'b0011101;
                m_sc     = sat(m_sc + 1);
            end else begin
                exp_ctrl = 7'b1111100;
            end
            m_mask = 0;
        end
        check("ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
              exp_ctrl);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
        ifid_use_rs1 = 0; ifid_use_rs2 = 0; idex_memread = 0;
        branch_taken = 0; halt_req = 0; resume = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        check("rst_stall", stall_cnt, 0);

        // Load-use on x5, then the bubble cycle
        idex_memread = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
        step();
        idex_memread = 0;
        step();
        check("lu_cnt", stall_cnt, 1);

        // Load-use against x0 does not stall
        idex_memread = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
        step();
        check("x0_cnt", stall_cnt, 1);

        // Branch overrides load-use
        do_reset();
        idex_memread = 1; idex_rd = 7; ifid_rs2 = 7; ifid_use_rs2 = 1; branch_taken = 1;
        step();
        idle();
        step();
        check("br_flush", flush_cnt, 1);
        check("br_stall", stall_cnt, 0);

        // Three-cycle memory wait then release
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        repeat (3) step();
        dmem_ready = 1;
        step();
        dmem_req = 0;
        step();
        check("mw_stall", stall_cnt, 3);

        // Timeout: sticky error halt, resume ignored, reset clears
        do_reset();
        dmem_req = 1; dmem_ready = 0;
        repeat (TO) step();
        check("to_err",  mem_err, 1);
        check("to_halt", halted,  1);
        dmem_req = 0; resume = 1;
        step();
        resume = 0;
        step();
        check("to_stay", halted, 1);
        rst = 1;
        step();
        rst = 0;
        check("to_rst_err",  mem_err,   0);
        check("to_rst_halt", halted,    0);
        check("to_rst_cnt",  stall_cnt, 0);

        // Halt/resume with halt_req held across resume
        do_reset();
        halt_req = 1;
        step();
        step();
        resume = 1;
        step();
        resume = 0;
        step();
        halt_req = 0;
        step();
        check("hr_run", halted, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            ifid_rs1     = 5'($urandom_range(0, 3));
            ifid_rs2     = 5'($urandom_range(0, 3));
            idex_rd      = 5'($urandom_range(0, 3));
            ifid_use_rs1 = 1'($urandom_range(0, 1));
            ifid_use_rs2 = 1'($urandom_range(0, 1));
            idex_memread = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            halt_req     = ($urandom_range(0, 15) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            dmem_req     = ($urandom_range(0, 2) == 0);
            dmem_ready   = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
